// File: rtl/dac_translator.sv
// I2S transmitter: divides clk into BCLK/LRCLK and shifts one buffered stereo
// pair per 64-BCLK frame out on DIN, MSB first, one BCLK after the LRCLK edge.
module dac_translator #(
    parameter int unsigned SAMPLE_BITS = 18,
    parameter int unsigned CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [SAMPLE_BITS-1:0] sample_l,
    input  logic [SAMPLE_BITS-1:0] sample_r,
    output logic                   sample_ready,
    output logic                   BCLK,
    output logic                   LRCLK,
    output logic                   DIN,
    output logic                   underrun
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned IDX_W   = $clog2(SAMPLE_BITS);
    localparam int unsigned FRAME_W = 6;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [FRAME_W-1:0] BIT_LAST  = FRAME_W'(63);
    localparam logic [4:0]         SLOT_LAST = 5'(SAMPLE_BITS);

    logic [DIV_W-1:0]       div_cnt_q,   div_cnt_d;
    logic [FRAME_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic                   bclk_q,      bclk_d;
    logic                   lrclk_q,     lrclk_d;
    logic                   din_q,       din_d;
    logic                   underrun_q,  underrun_d;
    logic                   next_full_q, next_full_d;
    logic [SAMPLE_BITS-1:0] next_l_q,    next_l_d;
    logic [SAMPLE_BITS-1:0] next_r_q,    next_r_d;
    logic [SAMPLE_BITS-1:0] frame_l_q,   frame_l_d;
    logic [SAMPLE_BITS-1:0] frame_r_q,   frame_r_d;

    logic                   fe;
    logic                   frame_load;
    logic                   xfer;
    logic [4:0]             slot;
    logic                   slot_active;
    logic [IDX_W-1:0]       bit_idx;
    logic [SAMPLE_BITS-1:0] word;

    // Divider, frame counter and serializer; everything serial moves on FE only.
    always_comb begin
        fe          = (div_cnt_q == DIV_LAST);
        div_cnt_d   = fe ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d      = (div_cnt_d >= DIV_HALF);

        frame_load  = fe && (bit_cnt_q == BIT_LAST);
        bit_cnt_d   = fe ? bit_cnt_q + FRAME_W'(1) : bit_cnt_q;

        slot        = bit_cnt_d[4:0];
        slot_active = (slot != 5'd0) && (slot <= SLOT_LAST);
        word        = bit_cnt_d[5] ? frame_r_q : frame_l_q;
        bit_idx     = '0;
        if (slot_active) begin
            bit_idx = IDX_W'(SAMPLE_BITS - 32'(slot));
        end

        lrclk_d     = fe ? bit_cnt_d[5] : lrclk_q;
        din_d       = fe ? (slot_active & word[bit_idx]) : din_q;
    end

    // Shadow buffer and frame load; a transfer during an underrun load lands in
    // the shadow and plays one frame later.
    always_comb begin
        xfer        = sample_valid && !next_full_q;
        next_full_d = next_full_q;
        next_l_d    = next_l_q;
        next_r_d    = next_r_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        underrun_d  = 1'b0;

        if (frame_load) begin
            next_full_d = 1'b0;
            underrun_d  = !next_full_q;
            frame_l_d   = next_full_q ? next_l_q : '0;
            frame_r_d   = next_full_q ? next_r_q : '0;
        end
        if (xfer) begin
            next_full_d = 1'b1;
            next_l_d    = sample_l;
            next_r_d    = sample_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= BIT_LAST;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b1;
            din_q       <= 1'b0;
            underrun_q  <= 1'b0;
            next_full_q <= 1'b0;
            next_l_q    <= '0;
            next_r_q    <= '0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            din_q       <= din_d;
            underrun_q  <= underrun_d;
            next_full_q <= next_full_d;
            next_l_q    <= next_l_d;
            next_r_q    <= next_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
        end
    end

    assign sample_ready = ~next_full_q;
    assign BCLK         = bclk_q;
    assign LRCLK        = lrclk_q;
    assign DIN          = din_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_dac_translator.sv
// Bench for dac_translator: cycle-count reference model of the I2S frame plus
// directed frame patterns, streaming, backpressure, random offers and reset.
module tb_dac_translator;

    localparam int unsigned SB = 18;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [SB-1:0] sample_l;
    logic [SB-1:0] sample_r;
    logic          sample_ready;
    logic          BCLK;
    logic          LRCLK;
    logic          DIN;
    logic          underrun;

    always #5 clk = ~clk;

    dac_translator #(.SAMPLE_BITS(SB), .CLK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_ready (sample_ready),
        .BCLK         (BCLK),
        .LRCLK        (LRCLK),
        .DIN          (DIN),
        .underrun     (underrun)
    );

    int          errors = 0;
    int          checks = 0;
    int          t;
    bit          m_full;
    logic [SB-1:0] sh_l, sh_r, fr_l, fr_r;
    logic [63:0] cap;
    logic [63:0] played[$];
    logic [63:0] exp_frames[$];
    int          ur_cnt;
    logic        prev_lr;
    int          last_rise;
    int          lr_period;
    bit          stream_on;
    int unsigned s_base;
    int unsigned s_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole frame as seen on DIN, bit 63 = slot 0 of the left half.
    function automatic logic [63:0] pack(input logic [SB-1:0] l, input logic [SB-1:0] r);
        logic [31:0] lh, rh;
        lh = 32'(l) << (31 - SB);
        rh = 32'(r) << (31 - SB);
        return {lh, rh};
    endfunction

    function automatic int load_time(input int m);
        return int'(D) * (1 + 64 * m);
    endfunction

    function automatic logic [63:0] stream_frame(input int unsigned i);
        logic [SB-1:0] l, r;
        l = SB'(s_base + i);
        r = SB'(~(s_base + i));
        return pack(l, r);
    endfunction

    task automatic drive_stream();
        sample_l = SB'(s_base + s_cnt);
        sample_r = SB'(~(s_base + s_cnt));
    endtask

    task automatic reset_model();
        t         = 0;
        m_full    = 1'b0;
        sh_l      = '0;
        sh_r      = '0;
        fr_l      = '0;
        fr_r      = '0;
        cap       = '0;
        exp_frames.delete();
        prev_lr   = 1'b1;
        last_rise = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bclk"},     64'(BCLK),         64'(0));
        chk({tag, "_lrclk"},    64'(LRCLK),        64'(1));
        chk({tag, "_din"},      64'(DIN),          64'(0));
        chk({tag, "_underrun"}, 64'(underrun),     64'(0));
        chk({tag, "_ready"},    64'(sample_ready), 64'(1));
    endtask

    // One clk of the reference model plus per-cycle output checks.
    task automatic step();
        int          k, ph, pos;
        bit          load, xfer, exp_ur;
        logic [63:0] f;
        @(posedge clk);
        t++;
        k    = t / int'(D);
        ph   = t % int'(D);
        load = (ph == 0) && (k >= 1) && (((k - 1) % 64) == 0);
        xfer = (sample_valid === 1'b1) && !m_full;
        exp_ur = 1'b0;
        if (load) begin
            if (m_full) begin
                fr_l   = sh_l;
                fr_r   = sh_r;
                m_full = 1'b0;
            end else begin
                fr_l   = '0;
                fr_r   = '0;
                exp_ur = 1'b1;
            end
            exp_frames.push_back(pack(fr_l, fr_r));
        end
        if (xfer) begin
            sh_l   = sample_l;
            sh_r   = sample_r;
            m_full = 1'b1;
        end
        #1;
        pos = (k == 0) ? 63 : (k - 1) % 64;
        f   = pack(fr_l, fr_r);
        chk("bclk",     64'(BCLK),         64'(ph >= int'(D) / 2));
        chk("lrclk",    64'(LRCLK),        64'(pos >= 32));
        chk("din",      64'(DIN),          64'(f[63 - pos]));
        chk("underrun", 64'(underrun),     64'(exp_ur));
        chk("ready",    64'(sample_ready), 64'(!m_full));
        if (underrun === 1'b1) ur_cnt++;
        if (k >= 1 && ph == int'(D) / 2) begin
            cap[63 - pos] = DIN;
            if (pos == 63) begin
                played.push_back(cap);
                chk("frame", cap, (exp_frames.size() > 0) ? exp_frames.pop_front() : 64'hx);
            end
        end
        if (LRCLK === 1'b1 && prev_lr === 1'b0) begin
            if (last_rise >= 0) lr_period = t - last_rise;
            last_rise = t;
        end
        prev_lr = LRCLK;
        if (stream_on && xfer) begin
            s_cnt++;
            drive_stream();
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    initial begin
        logic [SB-1:0] l1, r1, a_l, a_r, b_l, b_r;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        stream_on    = 1'b0;
        ur_cnt       = 0;
        lr_period    = 0;
        s_base       = 0;
        s_cnt        = 0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Single pair transferred before the first FE.
        sample_l = 18'h2AAAA;
        sample_r = 18'h15555;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("ready_after_xfer", 64'(sample_ready), 64'(0));
        step();
        step();
        chk("bclk_high_t3", 64'(BCLK), 64'(1));
        step();
        chk("first_fall", 64'(BCLK), 64'(0));
        chk("first_fe_lrclk", 64'(LRCLK), 64'(0));
        chk("ready_after_load", 64'(sample_ready), 64'(1));

        // Underrun at frame 1 with a transfer in the same FE cycle.
        run_to(load_time(1) - 1);
        l1 = SB'($urandom);
        r1 = SB'($urandom);
        sample_l = l1;
        sample_r = r1;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("underrun_pulse", 64'(underrun), 64'(1));
        chk("same_fe_xfer", 64'(sample_ready), 64'(0));
        step();
        chk("underrun_width", 64'(underrun), 64'(0));
        run_to(load_time(2) + 1);
        chk("single_pair", played[0], 64'h55554000_2AAAA000);
        chk("silent_frame", played[1], 64'h0);
        chk("underrun_count1", 64'(ur_cnt), 64'(1));

        // Backpressure: second value held on the bus while the shadow is full.
        a_l = SB'($urandom); a_r = SB'($urandom);
        b_l = SB'($urandom); b_r = SB'($urandom);
        sample_l = a_l;
        sample_r = a_r;
        sample_valid = 1'b1;
        step();
        sample_l = b_l;
        sample_r = b_r;
        repeat (10) step();
        chk("bp_hold", 64'(sample_ready), 64'(0));
        run_to(load_time(3));
        chk("bp_ready_back", 64'(sample_ready), 64'(1));
        step();
        sample_valid = 1'b0;
        chk("bp_second_xfer", 64'(sample_ready), 64'(0));
        run_to(load_time(5) + 1);
        chk("after_underrun", played[2], pack(l1, r1));
        chk("bp_first", played[3], pack(a_l, a_r));
        chk("bp_second", played[4], pack(b_l, b_r));
        chk("underrun_count2", 64'(ur_cnt), 64'(2));

        // Streaming for 8 frames with an incrementing producer.
        s_base = $urandom;
        s_cnt  = 0;
        drive_stream();
        sample_valid = 1'b1;
        stream_on    = 1'b1;
        run_to(load_time(13));
        stream_on    = 1'b0;
        sample_valid = 1'b0;
        chk("stream_no_underrun", 64'(ur_cnt), 64'(2));
        chk("lrclk_period", 64'(lr_period), 64'(256));

        // Extremes after an underrun frame.
        run_to(load_time(14));
        sample_l = 18'h20000;
        sample_r = 18'h1FFFF;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("underrun_count3", 64'(ur_cnt), 64'(3));
        for (int i = 0; i < 8; i++) begin
            chk("stream", played[6 + i], stream_frame(i));
        end

        // Random offers at random points in each frame.
        for (int m = 16; m <= 21; m++) begin
            run_to(load_time(m - 1) + 1 + int'($urandom_range(0, 250)));
            if ($urandom_range(0, 3) != 0) begin
                sample_l = SB'($urandom);
                sample_r = SB'($urandom);
                sample_valid = 1'b1;
                step();
                sample_valid = 1'b0;
            end
        end
        run_to(load_time(22) + 1);
        chk("pre_extreme_silent", played[14], 64'h0);
        chk("extremes", played[15], 64'h40000000_3FFFE000);

        // Mid-frame reset with a full shadow.
        sample_l = SB'($urandom);
        sample_r = SB'($urandom);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (40) step();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        reset_model();
        rst = 1'b0;
        run_to(load_time(0));
        chk("shadow_discarded", 64'(underrun), 64'(1));
        run_to(load_time(1) + 1);
        chk("post_reset_silent", played[played.size() - 1], 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_translator.md
# dac_translator

Serializes stereo PCM samples onto an I2S link for an external DAC/amplifier; the transmit counterpart of the microphone receiver in the audio path. It generates BCLK and LRCLK from the system clock, accepts one stereo sample pair per frame through a valid/ready handshake into a one-entry shadow buffer, and shifts samples out MSB-first with the standard one-BCLK I2S delay. Missing samples produce a silent frame and an underrun pulse.

## Interface
- SAMPLE_BITS, 18, bits per channel sample, two's complement; legal range 8..31.
- CLK_DIV, 4, clk cycles per BCLK period; even, ≥ 2.
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample_l/sample_r hold a valid stereo pair.
- sample_l  in  SAMPLE_BITS  left-channel sample.
- sample_r  in  SAMPLE_BITS  right-channel sample.
- sample_ready  out  1  shadow buffer empty; transfer occurs when sample_valid && sample_ready at a posedge clk.
- BCLK  out  1  I2S bit clock, registered.
- LRCLK  out  1  I2S word select; 0 = left, 1 = right.
- DIN  out  1  serial data to DAC.
- underrun  out  1  one-clk pulse when a frame starts with no sample buffered.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. BCLK <= 1 when next div_cnt ≥ CLK_DIV/2, else 0. The falling-edge event (FE) is the clk cycle in which div_cnt wraps from CLK_DIV-1 to 0. LRCLK, DIN and bit_cnt update only on FE.
- Frame: bit_cnt counts 0..63 and advances by 1 per FE, wrapping 63→0. That gives 32 BCLK per channel and 64 per frame.
- LRCLK: after the FE update, 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
- DIN:
  - bit_cnt = n in 1..SAMPLE_BITS: left[SAMPLE_BITS-n], so the MSB appears at n=1.
  - bit_cnt = 32+n: right[SAMPLE_BITS-n].
  - All other slots, including 0 and 32: 0.
- Shadow buffer: holds next_l, next_r and next_full. sample_ready = ~next_full, driven combinationally from the register.
  - On a transfer, next_l/next_r <= sample_l/sample_r and next_full <= 1.
- Frame load happens on the FE where bit_cnt wraps 63→0.
  - If next_full: frame registers <= shadow, and next_full <= 0.
  - Else: frame registers <= 0 and underrun <= 1 for exactly one clk.
  - No bypass. A transfer in the same cycle as an underrun load goes to the shadow and plays in the following frame.
- Samples are passed unmodified; no scaling or calibration offset.
- Reset (asynchronous, takes effect immediately, any state):
  - div_cnt=0, bit_cnt=63, next_full=0, frame registers=0.
  - Outputs: BCLK=0, LRCLK=1, DIN=0, underrun=0, sample_ready=1.
  - A reset mid-frame abandons the current frame and discards the shadow contents.

## Timing
- The first FE occurs at the CLK_DIV-th posedge clk after rst deasserts. It loads frame 0 with bit_cnt=0, LRCLK=0, DIN=0.
- The left MSB appears on DIN at the second FE. BCLK rises mid-bit, so each bit is stable around the BCLK rising edge.
- Frame period = 64·CLK_DIV clk cycles; sample rate = f_clk/(64·CLK_DIV).
- sample_ready:
  - deasserts in the cycle after a transfer;
  - reasserts in the clk cycle after the frame-load FE.
  - The producer therefore has one full frame minus one cycle to supply the next pair without underrun.
- underrun is registered and coincides with the FE that wraps bit_cnt to 0.
- sample_valid held high while sample_ready=0 causes no transfer and no state change.

## Test plan
- Reset values: assert rst mid-operation. Immediately BCLK=0, LRCLK=1, DIN=0, underrun=0, sample_ready=1. After release, the first BCLK fall is exactly CLK_DIV clks later.
- Single pair (SAMPLE_BITS=18, CLK_DIV=4): transfer L=18'h2AAAA, R=18'h15555 before the first FE. Sampled on BCLK rises:
  - LRCLK=0 for 32 bits; DIN = 0, then 1,0,1,0… (18 bits), then 13 zeros;
  - LRCLK=1 for 32 bits; DIN = 0, then 0,1,0,1… (18 bits), then 13 zeros.
- Underrun: no transfer for frame 1. Frame 1 DIN is all zeros and underrun pulses exactly once, 1 clk wide, at its start. A pair transferred in that same FE cycle plays in frame 2.
- Streaming: producer keeps sample_valid=1 with an incrementing counter for 8 frames.
  - Exactly one transfer per frame; no underrun.
  - Decoded left/right values equal the inputs in order.
  - LRCLK period = 256 clk.
- Backpressure: after a transfer, hold sample_valid=1 with a new value. The shadow is not overwritten until sample_ready reasserts, and the first value plays before the second.
- Extremes: L=18'h20000 (most negative), R=18'h1FFFF. The serial bits match exactly, with no bits leaking into padding slots across the frame wrap.
